// File: rtl/comparator_3bit.sv
// Registered magnitude comparator with optional two's-complement mode and
// saturating per-result event counters.
module comparator_3bit #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cnt_clr,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             A_gt_B,
    output logic             out_valid,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One extra bit lets a single signed compare cover both modes: sign-extend
    // in signed mode, zero-extend in unsigned mode.
    logic signed [WIDTH:0] w_a_ext;
    logic signed [WIDTH:0] w_b_ext;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_gt;
    logic [2:0]            w_inc;

    assign w_a_ext = {signed_mode & A[WIDTH-1], A};
    assign w_b_ext = {signed_mode & B[WIDTH-1], B};
    assign w_eq    = (A == B);
    assign w_lt    = (w_a_ext < w_b_ext);
    assign w_gt    = ~w_eq & ~w_lt;
    assign w_inc   = {in_valid & w_gt, in_valid & w_lt, in_valid & w_eq};

    logic r_eq;
    logic r_lt;
    logic r_gt;
    logic r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_eq <= w_eq;
                r_lt <= w_lt;
                r_gt <= w_gt;
            end
        end
    end

    // Index 0 = equal, 1 = less-than, 2 = greater-than.
    logic [CNT_W-1:0] r_cnt [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (cnt_clr) begin
                    r_cnt[gi] <= '0;
                end else if (w_inc[gi] && (r_cnt[gi] != CNT_MAX)) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign A_eq_B    = r_eq;
    assign A_lt_B    = r_lt;
    assign A_gt_B    = r_gt;
    assign out_valid = r_valid;
    assign eq_cnt    = r_cnt[0];
    assign lt_cnt    = r_cnt[1];
    assign gt_cnt    = r_cnt[2];

endmodule

// File: tb/tb_comparator_3bit.sv
// Self-checking bench for comparator_3bit: directed scenarios followed by
// randomized traffic, all checked against an arithmetic reference model.
module tb_comparator_3bit;

    localparam int WIDTH   = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cnt_clr;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             A_gt_B;
    logic             out_valid;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] gt_cnt;

    comparator_3bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .cnt_clr    (cnt_clr),
        .A_eq_B     (A_eq_B),
        .A_lt_B     (A_lt_B),
        .A_gt_B     (A_gt_B),
        .out_valid  (out_valid),
        .eq_cnt     (eq_cnt),
        .lt_cnt     (lt_cnt),
        .gt_cnt     (gt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: last result flags, valid pulse and counters.
    int m_eq, m_lt, m_gt, m_ov;
    int m_cnt_eq, m_cnt_lt, m_cnt_gt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int op_value(input int v, input int sm);
        if (sm != 0 && v >= (1 << (WIDTH - 1))) return v - (1 << WIDTH);
        return v;
    endfunction

    task automatic model_reset();
        m_eq = 0; m_lt = 0; m_gt = 0; m_ov = 0;
        m_cnt_eq = 0; m_cnt_lt = 0; m_cnt_gt = 0;
    endtask

    task automatic model_step(input int v, input int sm, input int a, input int b, input int clr);
        int va, vb;
        va = op_value(a, sm);
        vb = op_value(b, sm);
        m_ov = v;
        if (v != 0) begin
            m_eq = (va == vb) ? 1 : 0;
            m_lt = (va <  vb) ? 1 : 0;
            m_gt = (va >  vb) ? 1 : 0;
        end
        if (clr != 0) begin
            m_cnt_eq = 0; m_cnt_lt = 0; m_cnt_gt = 0;
        end else if (v != 0) begin
            if (va == vb)     m_cnt_eq = (m_cnt_eq < CNT_SAT) ? m_cnt_eq + 1 : CNT_SAT;
            else if (va < vb) m_cnt_lt = (m_cnt_lt < CNT_SAT) ? m_cnt_lt + 1 : CNT_SAT;
            else              m_cnt_gt = (m_cnt_gt < CNT_SAT) ? m_cnt_gt + 1 : CNT_SAT;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".eq"},     int'(A_eq_B),    m_eq);
        check({tag, ".lt"},     int'(A_lt_B),    m_lt);
        check({tag, ".gt"},     int'(A_gt_B),    m_gt);
        check({tag, ".ov"},     int'(out_valid), m_ov);
        check({tag, ".eq_cnt"}, int'(eq_cnt),    m_cnt_eq);
        check({tag, ".lt_cnt"}, int'(lt_cnt),    m_cnt_lt);
        check({tag, ".gt_cnt"}, int'(gt_cnt),    m_cnt_gt);
    endtask

    // Called just after a falling edge: drive, clock once, check at the next falling edge.
    task automatic cycle(input string tag, input int v, input int sm, input int a, input int b,
                         input int clr, input bit verbose);
        in_valid    = v[0];
        signed_mode = sm[0];
        A           = a[WIDTH-1:0];
        B           = b[WIDTH-1:0];
        cnt_clr     = clr[0];
        @(posedge clk);
        model_step(v, sm, a, b, clr);
        @(negedge clk);
        check_all(tag);
        if (verbose)
            $display("%s: v=%0d s=%0d A=%0d B=%0d clr=%0d -> eq=%0b lt=%0b gt=%0b ov=%0b cnt=%0d/%0d/%0d",
                     tag, v, sm, a, b, clr, A_eq_B, A_lt_B, A_gt_B, out_valid, eq_cnt, lt_cnt, gt_cnt);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0;
        A = '0; B = '0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("idle");

        // Scenario 1 and 2: unsigned equal then back-to-back compares.
        cycle("s1_eq", 1, 0, 0, 0, 0, 1);
        cycle("s2_a", 1, 0, 1, 0, 0, 1);
        cycle("s2_b", 1, 0, 2, 3, 0, 1);
        cycle("s2_c", 1, 0, 4, 2, 0, 1);
        cycle("s2_d", 1, 0, 7, 7, 0, 1);
        check("s2_gt_total", int'(gt_cnt), 2);
        check("s2_lt_total", int'(lt_cnt), 1);
        check("s2_eq_total", int'(eq_cnt), 2);

        // Scenario 3: signed versus unsigned ordering of the same bit patterns.
        cycle("s3_sgn_a", 1, 1, 4, 2, 0, 1);
        check("s3_sgn_a_lt", int'(A_lt_B), 1);
        cycle("s3_sgn_b", 1, 1, 7, 0, 0, 1);
        check("s3_sgn_b_lt", int'(A_lt_B), 1);
        cycle("s3_uns_a", 1, 0, 4, 2, 0, 1);
        check("s3_uns_a_gt", int'(A_gt_B), 1);
        cycle("s3_uns_b", 1, 0, 7, 0, 0, 1);
        check("s3_uns_b_gt", int'(A_gt_B), 1);

        // Scenario 4: idle cycles with changing operands and mode must not disturb state.
        for (int i = 0; i < 3; i++) cycle("s4_idle", 0, i & 1, i, 7 - i, 0, 1);

        // Scenario 5: saturate the equal counter, then clear with a simultaneous compare.
        for (int i = 0; i < (1 << CNT_W) + 2; i++) cycle("s5_sat", 1, 0, i % 8, i % 8, 0, 0);
        check("s5_eq_sat", int'(eq_cnt), CNT_SAT);
        cycle("s5_clr", 1, 0, 3, 5, 1, 1);
        check("s5_clr_lt_flag", int'(A_lt_B), 1);
        check("s5_clr_lt_cnt", int'(lt_cnt), 0);

        // Scenario 6: asynchronous reset between edges while a result is showing.
        cycle("s6_pre", 1, 0, 6, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("s6_async");
        @(negedge clk);
        check_all("s6_hold");
        rst_n = 1'b1;
        cycle("s6_first", 1, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int v, sm, a, b, clr;
            v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            sm  = int'($urandom_range(0, 1));
            a   = int'($urandom_range(0, (1 << WIDTH) - 1));
            b   = ($urandom_range(0, 4) == 0) ? a : int'($urandom_range(0, (1 << WIDTH) - 1));
            clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
            cycle("rnd", v, sm, a, b, clr, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
